// File: rtl/tdc_sched_pkg.sv
// tdc_sched_pkg: shared state encoding and default widths for the TDC shot scheduler
package tdc_sched_pkg;
  localparam int SHOTS_W = 8;
  localparam int TMO_W = 16;
  localparam int GAP_W = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } sched_state_t;
endpackage

// File: rtl/tdc_shot_sched_if.sv
// tdc_shot_sched_if: start pulse and result-stream handshake between scheduler and tdc_top
interface tdc_shot_sched_if;
  logic tdc_start;
  logic tdc_ovalid;
  logic tdc_olast;
  logic tdc_oready;
  modport master (output tdc_start, output tdc_oready, input tdc_ovalid, input tdc_olast);
  modport slave (input tdc_start, input tdc_oready, output tdc_ovalid, output tdc_olast);
endinterface

// File: rtl/tdc_sched_timer.sv
// tdc_sched_timer: single up-counter shared by the gap and per-shot timeout phases
module tdc_sched_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         hit
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (load) count <= '0;
    else if (en) count <= count + 1'b1;
  end
  // hit marks the cycle whose increment reaches target; a zero target never hits
  assign hit = ({1'b0, count} + 1'b1) == {1'b0, target};
endmodule

// File: rtl/tdc_shot_sched.sv
// tdc_shot_sched: sequences a frame of TDC shots with per-shot timeout, inter-shot gap and irq
module tdc_shot_sched #(
  parameter int SHOTS_W = tdc_sched_pkg::SHOTS_W,
  parameter int TMO_W = tdc_sched_pkg::TMO_W,
  parameter int GAP_W = tdc_sched_pkg::GAP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en,
  input  logic [SHOTS_W-1:0]  cfg_shots,
  input  logic [GAP_W-1:0]    cfg_gap,
  input  logic [TMO_W-1:0]    cfg_timeout,
  input  logic                frame_start,
  tdc_shot_sched_if.master    tdc,
  input  logic                ds_ready,
  output logic                frame_busy,
  output logic                frame_done,
  output logic                frame_abort,
  output logic [SHOTS_W-1:0]  shot_cnt,
  output logic [7:0]          tmo_cnt,
  output logic                irq,
  input  logic                irq_clr
);
  import tdc_sched_pkg::*;
  sched_state_t state, nxt;
  logic [SHOTS_W-1:0] shots_q;
  logic [GAP_W-1:0] gap_q;
  logic [TMO_W-1:0] tmo_q;
  logic abort_q, irq_q, in_wait, in_gap, last_beat, hit, shot_done, timed_out, last_shot, accept;
  assign in_wait = state == WAIT;
  assign in_gap = state == GAP;
  assign accept = state == IDLE && frame_start && cfg_en;
  assign tdc.tdc_start = state == START;
  assign tdc.tdc_oready = ds_ready & in_wait;
  assign last_beat = tdc.tdc_ovalid & tdc.tdc_oready & tdc.tdc_olast;
  assign shot_done = in_wait & (last_beat | hit);
  // the last-beat handshake beats a simultaneous timeout
  assign timed_out = in_wait & hit & ~last_beat;
  assign last_shot = SHOTS_W'(shot_cnt + 1'b1) == shots_q;
  assign frame_busy = state != IDLE;
  assign frame_done = state == DONE;
  assign frame_abort = abort_q;
  assign irq = irq_q | frame_done;
  tdc_sched_timer #(.W(TMO_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (~(in_wait | in_gap) | shot_done),
    .en     (in_wait | in_gap),
    .target (in_wait ? tmo_q : TMO_W'(gap_q)),
    .hit    (hit)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? START : IDLE;
      START:   nxt = cfg_en ? WAIT : DONE;
      WAIT:    nxt = !shot_done ? WAIT : (last_shot || !cfg_en) ? DONE : (gap_q == '0) ? START : GAP;
      GAP:     nxt = !cfg_en ? DONE : hit ? START : GAP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shots_q <= '0;
      gap_q <= '0;
      tmo_q <= '0;
      shot_cnt <= '0;
      tmo_cnt <= '0;
      abort_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state <= nxt;
      abort_q <= nxt == DONE && !(in_wait && last_shot);
      irq_q <= frame_done | (irq_q & ~irq_clr);
      if (accept) begin
        shots_q <= (cfg_shots == '0) ? SHOTS_W'(1) : cfg_shots;
        gap_q <= cfg_gap;
        tmo_q <= cfg_timeout;
        shot_cnt <= '0;
        tmo_cnt <= '0;
      end
      if (shot_done) shot_cnt <= shot_cnt + 1'b1;
      if (timed_out && tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_tdc_shot_sched.sv
// tb_tdc_shot_sched: scenario bench with a frame-result scoreboard for tdc_shot_sched
module tb_tdc_shot_sched;
  localparam int SW = 8;
  localparam int TW = 16;
  localparam int GW = 8;
  typedef struct packed {
    logic [SW-1:0] shots;
    logic [7:0]    tmo;
    logic          abort;
    logic          irq;
  } res_t;
  logic clk = 0, rst_n = 0, cfg_en = 0, frame_start = 0, ds_ready = 1, irq_clr = 0;
  logic [SW-1:0] cfg_shots = 0;
  logic [GW-1:0] cfg_gap = 0;
  logic [TW-1:0] cfg_timeout = 0;
  logic frame_busy, frame_done, frame_abort, irq;
  logic [SW-1:0] shot_cnt;
  logic [7:0] tmo_cnt;
  res_t exp_q[$];
  int cyc = 0, n_starts = 0, pass_cnt = 0, total = 0;
  tdc_shot_sched_if tdc ();
  tdc_shot_sched #(.SHOTS_W(SW), .TMO_W(TW), .GAP_W(GW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_en      (cfg_en),
    .cfg_shots   (cfg_shots),
    .cfg_gap     (cfg_gap),
    .cfg_timeout (cfg_timeout),
    .frame_start (frame_start),
    .tdc         (tdc),
    .ds_ready    (ds_ready),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .shot_cnt    (shot_cnt),
    .tmo_cnt     (tmo_cnt),
    .irq         (irq),
    .irq_clr     (irq_clr)
  );
  always #2 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tdc.tdc_start) n_starts <= n_starts + 1;
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  // request a frame and push its expected end result; config is scrambled afterwards
  task automatic go(int shots, int gap, int tmo, res_t e);
    cfg_shots = SW'(shots);
    cfg_gap = GW'(gap);
    cfg_timeout = TW'(tmo);
    cfg_en = 1;
    frame_start = 1;
    exp_q.push_back(e);
    tick();
    frame_start = 0;
    cfg_shots = 8'd200;
    cfg_gap = 8'd1;
    cfg_timeout = 16'd3;
  endtask
  task automatic wait_start(output int c, output bit ok);
    ok = 0;
    c = -1;
    for (int i = 0; i < 60; i++) begin
      if (tdc.tdc_start) begin
        ok = 1;
        c = cyc;
        return;
      end
      tick();
    end
  endtask
  task automatic wait_done(output int c, output bit ok);
    ok = 0;
    c = -1;
    for (int i = 0; i < 60; i++) begin
      if (frame_done) begin
        ok = 1;
        c = cyc;
        return;
      end
      tick();
    end
  endtask
  // present a last beat dly cycles after the current cycle; m is the accept cycle
  task automatic reply(int dly, output int m, output bit ok);
    ok = 0;
    m = -1;
    tick(dly);
    tdc.tdc_ovalid = 1;
    tdc.tdc_olast = 1;
    for (int i = 0; i < 60; i++) begin
      if (tdc.tdc_oready) begin
        ok = 1;
        m = cyc;
        break;
      end
      tick();
    end
    tick();
    tdc.tdc_ovalid = 0;
    tdc.tdc_olast = 0;
  endtask
  task automatic test_reset;
    logic [21:0] v;
    rst_n = 0;
    tick(2);
    v = {tdc.tdc_start, tdc.tdc_oready, frame_busy, frame_done, frame_abort, shot_cnt, tmo_cnt, irq};
    total++;
    if (v !== 22'd0) $display("FAIL reset_outputs got=%h want=0", v);
    else pass_cnt++;
    rst_n = 1;
    tick();
  endtask
  task automatic test_single;
    int a, m, d, s0;
    bit ok1, ok2, ok3;
    res_t e, got;
    s0 = n_starts;
    go(1, 0, 0, '{shots: 1, tmo: 0, abort: 0, irq: 1});
    total++;
    if (tdc.tdc_start !== 1'b1) $display("FAIL single_start_latency got=%b want=1", tdc.tdc_start);
    else pass_cnt++;
    wait_start(a, ok1);
    reply(5, m, ok2);
    wait_done(d, ok3);
    total++;
    if (!(ok1 && ok2 && ok3) || m - a != 5 || d - m != 1)
      $display("FAIL single_timing got beat=+%0d done=+%0d want beat=+5 done=+1", m - a, d - m);
    else pass_cnt++;
    e = exp_q.pop_front();
    got = {shot_cnt, tmo_cnt, frame_abort, irq};
    total++;
    if (got !== e) $display("FAIL single_result got=%h want=%h", got, e);
    else pass_cnt++;
    tick();
    total++;
    if (n_starts - s0 != 1) $display("FAIL single_start_count got=%0d want=1", n_starts - s0);
    else pass_cnt++;
  endtask
  task automatic test_multi_gap;
    int a, m, d;
    bit ok, ok2;
    res_t e, got;
    go(3, 4, 0, '{shots: 3, tmo: 0, abort: 0, irq: 1});
    for (int i = 0; i < 3; i++) begin
      wait_start(a, ok);
      if (i > 0) begin
        total++;
        if (!ok || a - m != 5) $display("FAIL gap_shot%0d_spacing got=%0d want=5", i, a - m);
        else pass_cnt++;
      end
      reply(2, m, ok2);
    end
    wait_done(d, ok);
    e = exp_q.pop_front();
    got = {shot_cnt, tmo_cnt, frame_abort, irq};
    total++;
    if (!ok || got !== e) $display("FAIL gap_result got=%h want=%h done_seen=%b", got, e, ok);
    else pass_cnt++;
    tick();
  endtask
  task automatic test_timeout;
    int a0, a1, d;
    bit ok0, ok1, ok2;
    res_t e, got;
    go(2, 0, 10, '{shots: 2, tmo: 2, abort: 0, irq: 1});
    wait_start(a0, ok0);
    tick();
    wait_start(a1, ok1);
    total++;
    if (!(ok0 && ok1) || a1 - a0 != 11) $display("FAIL timeout_shot1 got=%0d want=11", a1 - a0);
    else pass_cnt++;
    tick();
    wait_done(d, ok2);
    total++;
    if (!ok2 || d - a1 != 11) $display("FAIL timeout_shot2 got=%0d want=11", d - a1);
    else pass_cnt++;
    e = exp_q.pop_front();
    got = {shot_cnt, tmo_cnt, frame_abort, irq};
    total++;
    if (got !== e) $display("FAIL timeout_result got=%h want=%h", got, e);
    else pass_cnt++;
    tick();
  endtask
  task automatic test_race;
    int a, m, d;
    bit ok1, ok2, ok3;
    res_t e, got;
    go(1, 0, 6, '{shots: 1, tmo: 0, abort: 0, irq: 1});
    wait_start(a, ok1);
    reply(6, m, ok2);
    wait_done(d, ok3);
    total++;
    if (!(ok1 && ok2 && ok3) || m - a != 6 || d - m != 1)
      $display("FAIL race_timing got beat=+%0d done=+%0d want +6 +1", m - a, d - m);
    else pass_cnt++;
    e = exp_q.pop_front();
    got = {shot_cnt, tmo_cnt, frame_abort, irq};
    total++;
    if (got !== e) $display("FAIL race_result got=%h want=%h", got, e);
    else pass_cnt++;
    tick();
  endtask
  task automatic test_backpressure;
    int a;
    bit ok;
    res_t e, got;
    ds_ready = 0;
    go(1, 0, 0, '{shots: 1, tmo: 0, abort: 0, irq: 1});
    wait_start(a, ok);
    tick();
    tdc.tdc_ovalid = 1;
    tdc.tdc_olast = 1;
    tick(5);
    total++;
    if (tdc.tdc_oready !== 1'b0) $display("FAIL bp_oready_low got=%b want=0", tdc.tdc_oready);
    else pass_cnt++;
    total++;
    if ({frame_busy, frame_done, shot_cnt} !== {1'b1, 1'b0, 8'd0})
      $display("FAIL bp_no_completion got busy=%b done=%b shots=%0d want 1 0 0", frame_busy, frame_done, shot_cnt);
    else pass_cnt++;
    ds_ready = 1;
    #1;
    total++;
    if (tdc.tdc_oready !== 1'b1) $display("FAIL bp_oready_release got=%b want=1", tdc.tdc_oready);
    else pass_cnt++;
    tick();
    tdc.tdc_ovalid = 0;
    tdc.tdc_olast = 0;
    e = exp_q.pop_front();
    got = {shot_cnt, tmo_cnt, frame_abort, irq};
    total++;
    if (frame_done !== 1'b1 || got !== e) $display("FAIL bp_result got done=%b res=%h want done=1 res=%h", frame_done, got, e);
    else pass_cnt++;
    tick();
  endtask
  task automatic test_abort;
    int a, m, d, s0;
    bit ok1, ok2, ok3;
    res_t e, got;
    s0 = n_starts;
    go(4, 8, 0, '{shots: 1, tmo: 0, abort: 1, irq: 1});
    wait_start(a, ok1);
    reply(2, m, ok2);
    tick();
    cfg_en = 0;
    wait_done(d, ok3);
    total++;
    if (!(ok1 && ok2 && ok3) || d - m != 3) $display("FAIL abort_timing got=%0d want=3", d - m);
    else pass_cnt++;
    e = exp_q.pop_front();
    got = {shot_cnt, tmo_cnt, frame_abort, irq};
    total++;
    if (got !== e) $display("FAIL abort_result got=%h want=%h", got, e);
    else pass_cnt++;
    tick(3);
    total++;
    if (n_starts - s0 != 1) $display("FAIL abort_start_count got=%0d want=1", n_starts - s0);
    else pass_cnt++;
    cfg_en = 1;
  endtask
  task automatic test_irq_clr;
    int a, m, d;
    bit ok1, ok2, ok3;
    res_t e, got;
    irq_clr = 1;
    tick();
    irq_clr = 0;
    total++;
    if (irq !== 1'b0) $display("FAIL irq_clear_idle got=%b want=0", irq);
    else pass_cnt++;
    go(1, 0, 0, '{shots: 1, tmo: 0, abort: 0, irq: 1});
    wait_start(a, ok1);
    reply(1, m, ok2);
    wait_done(d, ok3);
    e = exp_q.pop_front();
    got = {shot_cnt, tmo_cnt, frame_abort, irq};
    total++;
    if (!(ok1 && ok2 && ok3) || got !== e) $display("FAIL irq_frame_result got=%h want=%h", got, e);
    else pass_cnt++;
    irq_clr = 1;
    tick();
    irq_clr = 0;
    total++;
    if (irq !== 1'b1) $display("FAIL irq_set_wins got=%b want=1", irq);
    else pass_cnt++;
    irq_clr = 1;
    tick();
    irq_clr = 0;
    total++;
    if (irq !== 1'b0) $display("FAIL irq_clear_after got=%b want=0", irq);
    else pass_cnt++;
  endtask
  task automatic test_zero_shots;
    int a, m, d;
    bit ok1, ok2, ok3;
    res_t e, got;
    go(0, 0, 0, '{shots: 1, tmo: 0, abort: 0, irq: 1});
    wait_start(a, ok1);
    reply(1, m, ok2);
    wait_done(d, ok3);
    e = exp_q.pop_front();
    got = {shot_cnt, tmo_cnt, frame_abort, irq};
    total++;
    if (!(ok1 && ok2 && ok3) || got !== e) $display("FAIL zero_shots_result got=%h want=%h", got, e);
    else pass_cnt++;
    tick();
  endtask
  task automatic test_reset_mid_wait;
    int a;
    bit ok, seen;
    logic [21:0] v;
    cfg_shots = 3;
    cfg_timeout = 0;
    cfg_en = 1;
    frame_start = 1;
    tick();
    frame_start = 0;
    wait_start(a, ok);
    tick(3);
    total++;
    if (!ok || tdc.tdc_oready !== 1'b1) $display("FAIL rst_pre_wait got=%b want=1", tdc.tdc_oready);
    else pass_cnt++;
    rst_n = 0;
    #1;
    v = {tdc.tdc_start, tdc.tdc_oready, frame_busy, frame_done, frame_abort, shot_cnt, tmo_cnt, irq};
    total++;
    if (v !== 22'd0) $display("FAIL rst_mid_wait got=%h want=0", v);
    else pass_cnt++;
    tick();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= frame_done | frame_busy;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL rst_no_done got=%b want=0", seen);
    else pass_cnt++;
  endtask
  initial begin
    tdc.tdc_ovalid = 0;
    tdc.tdc_olast = 0;
    test_reset();
    test_single();
    test_multi_gap();
    test_timeout();
    test_race();
    test_backpressure();
    test_abort();
    test_irq_clr();
    test_zero_shots();
    test_reset_mid_wait();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
